adder_share_arbiter: RTL and testbench
======================================

Name: adder_share_arbiter

Overview:
- Shares one N-bit combinational adder among R requesters using round-robin arbitration and valid/ready handshakes on every requester port and on the result port.
- Each requester presents an operand pair.
- The winner's operands are captured, summed, and returned as an (N+1)-bit sum tagged with the requester ID.
- Sits between client blocks and the single adder instance.

Parameters:
- N, 10, operand width in bits.
- R, 4, number of requesters (R >= 2).
- IDW, $clog2(R), requester ID width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  R  request valid; bit i belongs to requester i.
- req_ready  output  R  one-hot grant/accept; at most one bit high per cycle.
- req_a  input  R*N  operand A; requester i uses bits [i*N +: N].
- req_b  input  R*N  operand B; same packing as req_a.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- rsp_sum  output  N+1  zero-extended sum, carry in MSB.
- rsp_id  output  IDW  index of the requester that owns rsp_sum.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Reset (async assert, sync-deasserted externally):
  - state=IDLE; rsp_valid=0; rsp_sum=0; rsp_id=0; busy=0.
  - Operand registers=0.
  - last_grant=R-1, so requester 0 has top priority first.
- Reset mid-operation discards the in-flight transaction; no response is issued.
- State machine IDLE -> CALC -> RESP -> IDLE.
- IDLE:
  - If any req_valid is high, grant g = first requester with valid set, searching from last_grant+1 upward mod R.
  - req_ready[g]=1 in this same cycle (combinational from req_valid and last_grant; Moore on state).
  - At the clock edge: capture req_a[g], req_b[g] and g; set last_grant<=g; go to CALC.
  - If no requests, stay in IDLE with req_ready=0.
- CALC:
  - Adder output registered into rsp_sum; rsp_id<=captured g; rsp_valid<=1; go to RESP.
  - req_ready=0.
- RESP:
  - rsp_valid=1; rsp_sum and rsp_id held stable until rsp_ready=1.
  - On the rsp_valid&&rsp_ready edge: rsp_valid<=0, go to IDLE.
  - rsp_sum and rsp_id keep their last value after handoff.
- req_ready is 0 in CALC and RESP. New requests are accepted only in IDLE.
- Requesters must hold valid and operands stable until granted. Dropping valid before a grant is legal; that requester is simply skipped.
- Latency: grant at cycle T, rsp_valid first high at T+2. Minimum spacing between grants is 3 cycles when rsp_ready is tied high.
- Arithmetic: rsp_sum = {1'b0,A} + {1'b0,B}, full N+1 bits, never truncated, unsigned.
- Fairness: a requester that holds valid continuously is granted within R grants.
- last_grant updates only on a grant, never on idle cycles.
- Simultaneous events:
  - All R requesters valid: rotate 0,1,...,R-1,0,...
  - The requester last granted re-requests together with others: it gets lowest priority.
  - Only one requester valid: it is granted repeatedly.
- Wrap-around: search index wraps from R-1 to 0.
- busy = (state != IDLE).

Decomposition:
- Package adder_share_pkg:
  - state enum {IDLE, CALC, RESP}.
  - Default N, R constants.
  - Helper function for rotating one-hot priority select.
- Sub-module rr_arbiter:
  - Parameter R.
  - Inputs: req[R], last_grant, enable.
  - Outputs: one-hot grant[R] and encoded grant_id.
  - Purely combinational.
- The existing adder_Nbit is instantiated with N for the datapath.
- FSM, capture registers and response registers live in the top module.

Test Plan:
1. Reset, then only req_valid[0] with a=1, b=99 -> req_ready=4'b0001 that cycle; two cycles later rsp_valid=1, rsp_sum=100, rsp_id=0.
2. All four valid, rsp_ready=1, operands a=i, b=10*i -> grant order 0,1,2,3,0; sums 0,11,22,33,0; grants 3 cycles apart.
3. Overflow: a=1023, b=1023 -> rsp_sum=2046 (11'h7FE); a=1023, b=1 -> 1024.
4. Backpressure: rsp_ready=0 for 5 cycles in RESP with pending req_valid[2] -> rsp_sum and rsp_id stable, req_ready stays 0; after rsp_ready=1 requester 2 is granted the next cycle.
5. Assert rst_n=0 in CALC -> outputs return to reset values immediately; after release no stale response; first grant goes to lowest valid index from 0.
6. Requester 1 drops valid before its turn while 2 and 3 hold -> 1 is skipped; no X on req_ready; one-hot check on req_ready every cycle.

Source files
------------

// File: rtl/adder_share_pkg.sv
// rtl/adder_share_pkg.sv - shared types, defaults and round-robin pick helper for adder_share_arbiter
// Contents:
//   state_t   : IDLE -> CALC -> RESP sequencing of one shared-adder transaction
//   DEFAULT_N : default operand width
//   DEFAULT_R : default requester count
//   MAX_R     : widest request vector the pick helper handles
//   rr_pick   : 1 when requester i is the first valid one after 'last', wrapping mod r
package adder_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEFAULT_N = 10;
    localparam int DEFAULT_R = 4;
    localparam int MAX_R     = 32;

    // Rotating one-hot priority select, evaluated one bit position at a time.
    // The search starts just after 'last' so the previous winner ranks lowest.
    function automatic logic rr_pick(
        input logic [MAX_R-1:0] req,
        input int unsigned      last,
        input int unsigned      r,
        input int unsigned      i
    );
        logic        found;
        int unsigned sel;
        int unsigned idx;
        found = 1'b0;
        sel   = 0;
        for (int unsigned k = 1; k <= MAX_R; k++) begin
            if (k <= r) begin
                idx = last + k;
                // last < r and k <= r, so one subtraction is enough to wrap
                if (idx >= r) begin
                    idx = idx - r;
                end
                if (!found && (|(req & (MAX_R'(1) << idx)))) begin
                    found = 1'b1;
                    sel   = idx;
                end
            end
        end
        return found && (sel == i);
    endfunction

endpackage

// File: rtl/adder_Nbit.sv
// rtl/adder_Nbit.sv - unsigned N-bit combinational adder with carry out
// Ports:
//   a, b : N-bit unsigned operands
//   sum  : N+1-bit result, carry in the MSB
module adder_Nbit #(
    parameter int N = 10
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N:0]   sum
);

    assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, previous winner lowest priority
// Ports:
//   req        : request vector, bit i from requester i
//   last_grant : index of the most recent winner
//   enable     : when low no grant is issued
//   grant      : one-hot winner (all zero when disabled or no requests)
//   grant_id   : encoded winner index (0 when no grant)
// R must not exceed MAX_R from the package.
module rr_arbiter
    import adder_share_pkg::*;
#(
    parameter  int R   = DEFAULT_R,
    localparam int IDW = $clog2(R)
) (
    input  logic [R-1:0]   req,
    input  logic [IDW-1:0] last_grant,
    input  logic           enable,
    output logic [R-1:0]   grant,
    output logic [IDW-1:0] grant_id
);

    always_comb begin
        grant    = '0;
        grant_id = '0;
        if (enable) begin
            for (int i = 0; i < R; i++) begin
                if (rr_pick(MAX_R'(req), 32'(last_grant), R, i)) begin
                    grant[i] = 1'b1;
                    grant_id = IDW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - shares one N-bit adder among R requesters with round-robin arbitration
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   req_valid  : per-requester request valid
//   req_ready  : one-hot grant, only while idle
//   req_a/b    : packed operands, requester i at [i*N +: N]
//   rsp_valid  : result valid, held until rsp_ready
//   rsp_ready  : consumer accepts result
//   rsp_sum    : N+1-bit unsigned sum
//   rsp_id     : requester owning rsp_sum
//   busy       : a transaction is in flight
module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter  int N   = DEFAULT_N,
    parameter  int R   = DEFAULT_R,
    localparam int IDW = $clog2(R)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [R-1:0]   req_valid,
    output logic [R-1:0]   req_ready,
    input  logic [R*N-1:0] req_a,
    input  logic [R*N-1:0] req_b,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [N:0]     rsp_sum,
    output logic [IDW-1:0] rsp_id,
    output logic           busy
);

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [IDW-1:0] gid_q, gid_d;
    logic [IDW-1:0] last_grant_q, last_grant_d;
    logic [N:0]     rsp_sum_q, rsp_sum_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic           rsp_valid_q, rsp_valid_d;

    logic [R-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic [N:0]     adder_sum;

    // Grants are offered only while idle, so req_ready is naturally 0 in CALC/RESP.
    rr_arbiter #(
        .R (R)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .enable     (state_q == IDLE),
        .grant      (grant),
        .grant_id   (grant_id)
    );

    adder_Nbit #(
        .N (N)
    ) u_add (
        .a   (a_q),
        .b   (b_q),
        .sum (adder_sum)
    );

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        gid_d        = gid_q;
        last_grant_d = last_grant_q;
        rsp_sum_d    = rsp_sum_q;
        rsp_id_d     = rsp_id_q;
        rsp_valid_d  = rsp_valid_q;
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    for (int i = 0; i < R; i++) begin
                        if (grant[i]) begin
                            a_d = req_a[i*N +: N];
                            b_d = req_b[i*N +: N];
                        end
                    end
                    gid_d        = grant_id;
                    last_grant_d = grant_id;
                    state_d      = CALC;
                end
            end
            CALC: begin
                rsp_sum_d   = adder_sum;
                rsp_id_d    = gid_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                // Sum and id stay put after the handoff; only valid drops.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            gid_q        <= '0;
            // Pretend R-1 won last so requester 0 ranks highest after reset.
            last_grant_q <= IDW'(R - 1);
            rsp_sum_q    <= '0;
            rsp_id_q     <= '0;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            gid_q        <= gid_d;
            last_grant_q <= last_grant_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_id_q     <= rsp_id_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign req_ready = grant;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb/tb_adder_share_arbiter.sv - self-checking bench for adder_share_arbiter
module tb_adder_share_arbiter;

    localparam int N = 10;
    localparam int R = 4;

    logic           clk;
    logic           rst_n;
    logic [R-1:0]   req_valid;
    logic [R-1:0]   req_ready;
    logic [R*N-1:0] req_a;
    logic [R*N-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [N:0]     rsp_sum;
    logic [1:0]     rsp_id;
    logic           busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    adder_share_arbiter #(.N(N), .R(R)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*N +: N] = N'(a);
        req_b[i*N +: N] = N'(b);
    endtask

    function automatic int oh_idx(input logic [R-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < R; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic int rnd_op();
        return ($urandom_range(0, 7) == 0) ? 1023 : int'($urandom_range(0, 1023));
    endfunction

    // ---------------- transaction-level reference model ----------------
    // Rules: grants only when nothing is outstanding; winner = first valid
    // requester after the previous winner (mod R); the result appears two
    // cycles after the grant and stays until accepted.
    typedef struct {
        int sum;
        int id;
    } rsp_t;

    rsp_t m_q[$];
    int   m_last = R - 1;
    bit   m_busy = 1'b0;
    int   m_age  = 0;

    task automatic monitor_step();
        int   pick;
        int   idx;
        int   exp_ready;
        bit   exp_rv;
        rsp_t t;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_age  = 0;
            m_last = R - 1;
            m_q.delete();
            chk("rst_rsp_valid", int'(rsp_valid), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_rsp_sum", int'(rsp_sum), 0);
            chk("rst_rsp_id", int'(rsp_id), 0);
        end else begin
            chk("ready_known", int'($isunknown(req_ready)), 0);
            chk("ready_onehot", int'($countones(req_ready) <= 1), 1);
            pick = -1;
            if (!m_busy) begin
                for (int k = 1; k <= R; k++) begin
                    idx = (m_last + k) % R;
                    if (pick < 0 && req_valid[idx]) pick = idx;
                end
            end
            exp_ready = (pick >= 0) ? (1 << pick) : 0;
            exp_rv    = m_busy && (m_age >= 2);
            chk("mdl_ready", int'(req_ready), exp_ready);
            chk("mdl_busy", int'(busy), int'(m_busy));
            chk("mdl_rsp_valid", int'(rsp_valid), int'(exp_rv));
            if (exp_rv) begin
                if (m_q.size() == 0) begin
                    chk("mdl_queue_nonempty", 0, 1);
                end else begin
                    chk("mdl_rsp_sum", int'(rsp_sum), m_q[0].sum);
                    chk("mdl_rsp_id", int'(rsp_id), m_q[0].id);
                end
            end
            if (exp_rv && rsp_ready) begin
                m_busy = 1'b0;
                if (m_q.size() != 0) void'(m_q.pop_front());
            end else if (m_busy) begin
                m_age++;
            end
            if (pick >= 0) begin
                m_busy = 1'b1;
                m_age  = 1;
                m_last = pick;
                t.sum  = int'(req_a[pick*N +: N]) + int'(req_b[pick*N +: N]);
                t.id   = pick;
                m_q.push_back(t);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            monitor_step();
        end
    end

    // ---------------- directed + random stimulus ----------------
    typedef struct {
        int id;
        int a;
        int b;
        int sum;
    } vec_t;

    task automatic reset_pulse();
        rst_n     = 1'b0;
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(output int id, output int c);
        bit got;
        got = 1'b0;
        id  = -1;
        c   = 0;
        for (int t = 0; t < 8 && !got; t++) begin
            #1;
            if (req_ready != '0) begin
                got = 1'b1;
                id  = oh_idx(req_ready);
                c   = cyc;
            end else begin
                tick();
            end
        end
        if (!got) chk("grant_timeout", 0, 1);
    endtask

    initial begin
        vec_t        tbl[$];
        int          gid;
        int          gc;
        int          prev;
        logic [R-1:0] g;

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_rsp_sum", int'(rsp_sum), 0);
        chk("reset_rsp_id", int'(rsp_id), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_req_ready", int'(req_ready), 0);
        rst_n = 1'b1;
        tick();

        // single-requester vectors, including the carry-out corners
        tbl.push_back('{0, 1, 99, 100});
        tbl.push_back('{1, 1023, 1023, 2046});
        tbl.push_back('{2, 1023, 1, 1024});
        tbl.push_back('{3, 0, 0, 0});
        tbl.push_back('{3, 512, 511, 1023});
        tbl.push_back('{0, 700, 300, 1000});
        foreach (tbl[n]) begin
            set_op(tbl[n].id, tbl[n].a, tbl[n].b);
            req_valid = R'(1 << tbl[n].id);
            #1;
            chk("vec_grant", int'(req_ready), 1 << tbl[n].id);
            tick();
            req_valid = '0;
            #1;
            chk("vec_calc_rsp_valid", int'(rsp_valid), 0);
            chk("vec_calc_busy", int'(busy), 1);
            tick();
            chk("vec_rsp_valid", int'(rsp_valid), 1);
            chk("vec_rsp_sum", int'(rsp_sum), tbl[n].sum);
            chk("vec_rsp_id", int'(rsp_id), tbl[n].id);
            tick();
        end

        // all four requesting: rotation 0,1,2,3,0 with 3-cycle grant spacing
        reset_pulse();
        for (int i = 0; i < R; i++) set_op(i, i, 10 * i);
        req_valid = '1;
        prev = 0;
        for (int n = 0; n < 5; n++) begin
            wait_grant(gid, gc);
            chk("rot_order", gid, n % R);
            if (n > 0) chk("rot_spacing", gc - prev, 3);
            prev = gc;
            tick();
            tick();
            chk("rot_rsp_sum", int'(rsp_sum), 11 * (n % R));
            chk("rot_rsp_id", int'(rsp_id), n % R);
            if (n == 4) req_valid = '0;
            tick();
        end

        // backpressure with requester 2 pending
        set_op(0, 5, 6);
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        #1;
        chk("bp_grant0", int'(req_ready), 1);
        tick();
        set_op(2, 7, 8);
        req_valid = 4'b0100;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_valid", int'(rsp_valid), 1);
            chk("bp_rsp_sum", int'(rsp_sum), 11);
            chk("bp_rsp_id", int'(rsp_id), 0);
            chk("bp_ready_low", int'(req_ready), 0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_ready_low_handoff", int'(req_ready), 0);
        tick();
        #1;
        chk("bp_grant2", int'(req_ready), 4'b0100);
        tick();
        req_valid = '0;
        tick();
        chk("bp_rsp_sum2", int'(rsp_sum), 15);
        chk("bp_rsp_id2", int'(rsp_id), 2);
        tick();

        // reset while in CALC
        set_op(0, 3, 4);
        req_valid = 4'b0001;
        #1;
        chk("rc_grant0", int'(req_ready), 1);
        tick();
        chk("rc_busy_calc", int'(busy), 1);
        rst_n     = 1'b0;
        req_valid = 4'b1001;
        #1;
        chk("rc_rsp_valid", int'(rsp_valid), 0);
        chk("rc_busy", int'(busy), 0);
        chk("rc_rsp_sum", int'(rsp_sum), 0);
        chk("rc_rsp_id", int'(rsp_id), 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rc_first_grant", int'(req_ready), 4'b0001);
        chk("rc_no_stale", int'(rsp_valid), 0);
        tick();
        req_valid = '0;
        #1;
        chk("rc_calc_no_rsp", int'(rsp_valid), 0);
        tick();
        chk("rc_rsp_sum", int'(rsp_sum), 7);
        tick();

        // requester 1 drops before its turn and is skipped
        set_op(2, 100, 200);
        req_valid = 4'b0100;
        #1;
        chk("drop_grant2", int'(req_ready), 4'b0100);
        tick();
        set_op(1, 11, 22);
        set_op(3, 33, 44);
        req_valid = 4'b1110;
        tick();
        tick();
        #1;
        chk("drop_grant3", int'(req_ready), 4'b1000);
        tick();
        req_valid = 4'b0100;
        tick();
        tick();
        #1;
        chk("drop_skip1", int'(req_ready), 4'b0100);
        tick();
        req_valid = '0;
        tick();
        tick();

        // random traffic checked by the reference model
        for (int c = 0; c < 1500; c++) begin
            g = req_ready & req_valid;
            tick();
            for (int i = 0; i < R; i++) begin
                if (req_valid[i] && !g[i]) begin
                    if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                end else begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    set_op(i, rnd_op(), rnd_op());
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
        end

        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
